// File: rtl/isa_pkg.sv
// Shared types and timing defaults for the ISA bus master: FSM state enum,
// bus cycle-type encoding and the cycle-timer width helper.
package isa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_WAIT   = 3'd4,
    ST_HOLD   = 3'd5
  } isa_state_e;

  // Encoded as {io, write} so a latched command maps straight onto a strobe.
  typedef enum logic [1:0] {
    CYC_MEMR = 2'b00,
    CYC_MEMW = 2'b01,
    CYC_IOR  = 2'b10,
    CYC_IOW  = 2'b11
  } isa_cyc_e;

  localparam int DEF_SETUP_CYC   = 2;
  localparam int DEF_STROBE_CYC  = 6;
  localparam int DEF_HOLD_CYC    = 1;
  localparam int DEF_TIMEOUT_CYC = 1024;

  // Bits needed to hold (largest phase length - 1), never less than 1.
  function automatic int timer_width(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/isa_master_if.sv
// Host command/response channel plus the ISA bus pins of isa_master.
interface isa_master_if;

  // cmd: a transfer happens on a rising edge where cmd_valid and cmd_ready are
  // both high; cmd_valid may not depend on cmd_ready and the cmd_* fields are
  // only sampled in that cycle. rsp_valid is a one-cycle pulse with no ready.
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic        cmd_io;
  logic [19:0] cmd_addr;
  logic [7:0]  cmd_wdata;

  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;

  logic [19:0] bus_a;
  logic        bus_ale;
  logic        bus_aen;
  logic        bus_ior_l;
  logic        bus_iow_l;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic [7:0]  bus_d_out;
  logic        bus_d_oe;
  logic [7:0]  bus_d_in;
  logic        bus_rdy;

  modport master (
    input  cmd_valid, cmd_write, cmd_io, cmd_addr, cmd_wdata, bus_d_in, bus_rdy,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
    output bus_a, bus_ale, bus_aen, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l,
    output bus_d_out, bus_d_oe
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_io, cmd_addr, cmd_wdata, bus_d_in, bus_rdy,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
    input  bus_a, bus_ale, bus_aen, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l,
    input  bus_d_out, bus_d_oe
  );

endinterface

// File: rtl/isa_cycle_timer.sv
// Loadable down-counter with zero flag; one instance times every bus phase.
module isa_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/isa_master.sv
// ISA bus master: one host command -> ADDR/SETUP/STROBE/WAIT/HOLD bus cycle.
// Define ISA_MASTER_TIMEOUT_EN to abort wait states after TIMEOUT_CYC cycles.
module isa_master
  import isa_pkg::*;
#(
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int STROBE_CYC  = DEF_STROBE_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic         clk,
  input  logic         busreset,
  isa_master_if.master bus,
  output isa_state_e   state_dbg
);

  localparam int TMR_W = timer_width(SETUP_CYC, STROBE_CYC, HOLD_CYC, TIMEOUT_CYC);

  isa_state_e   state_q, state_d;
  isa_cyc_e     cyc_q;
  logic [19:0]  addr_q;
  logic [7:0]   wdata_q;
  logic [7:0]   rdata_q;
  logic         rsp_valid_q;
  logic         aen_q;
  logic         accept;
  logic         go_hold;
  logic         strobe_on;
  logic         is_write;
  logic         tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic         tmr_zero;
`ifdef ISA_MASTER_TIMEOUT_EN
  logic         tmo;
  logic         tmo_q;
`endif

  isa_cycle_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (busreset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign accept   = bus.cmd_valid && bus.cmd_ready;
  assign is_write = cyc_q[0];

  // Each phase loads (length - 1) on entry; the zero flag marks its last cycle.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    go_hold  = 1'b0;
`ifdef ISA_MASTER_TIMEOUT_EN
    tmo      = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ADDR;
      ST_ADDR: begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(SETUP_CYC - 1);
        state_d  = ST_SETUP;
      end
      ST_SETUP: if (tmr_zero) begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(STROBE_CYC - 1);
        state_d  = ST_STROBE;
      end
      ST_STROBE: if (tmr_zero) begin
        if (bus.bus_rdy) begin
          go_hold = 1'b1;
        end else begin
          state_d = ST_WAIT;
`ifdef ISA_MASTER_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TIMEOUT_CYC - 1);
`endif
        end
      end
      ST_WAIT: begin
        if (bus.bus_rdy) go_hold = 1'b1;
`ifdef ISA_MASTER_TIMEOUT_EN
        else if (tmr_zero) begin
          go_hold = 1'b1;
          tmo     = 1'b1;
        end
`endif
      end
      ST_HOLD:  if (tmr_zero) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (go_hold) begin
      state_d  = ST_HOLD;
      tmr_load = 1'b1;
      tmr_val  = TMR_W'(HOLD_CYC - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (busreset) begin
      state_q     <= ST_IDLE;
      cyc_q       <= CYC_MEMR;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      aen_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      aen_q       <= 1'b0;
      rsp_valid_q <= (state_q == ST_HOLD) && (state_d == ST_IDLE);
      if (accept) begin
        cyc_q   <= isa_cyc_e'({bus.cmd_io, bus.cmd_write});
        addr_q  <= bus.cmd_io ? {4'h0, bus.cmd_addr[15:0]} : bus.cmd_addr;
        wdata_q <= bus.cmd_wdata;
      end
`ifdef ISA_MASTER_TIMEOUT_EN
      if (go_hold && !is_write) rdata_q <= tmo ? 8'hFF : bus.bus_d_in;
`else
      if (go_hold && !is_write) rdata_q <= bus.bus_d_in;
`endif
    end
  end

`ifdef ISA_MASTER_TIMEOUT_EN
  // Sticky abort flag for the current command, reported alongside rsp_valid.
  always_ff @(posedge clk) begin
    if (busreset || accept) tmo_q <= 1'b0;
    else if (tmo)           tmo_q <= 1'b1;
  end
  assign bus.rsp_timeout = rsp_valid_q && tmo_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

  assign strobe_on      = (state_q == ST_STROBE) || (state_q == ST_WAIT);
  assign bus.cmd_ready  = (state_q == ST_IDLE) && !busreset;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rdata_q;
  assign bus.bus_a      = addr_q;
  assign bus.bus_ale    = (state_q == ST_ADDR);
  assign bus.bus_aen    = aen_q;
  assign bus.bus_memr_l = !(strobe_on && cyc_q == CYC_MEMR);
  assign bus.bus_memw_l = !(strobe_on && cyc_q == CYC_MEMW);
  assign bus.bus_ior_l  = !(strobe_on && cyc_q == CYC_IOR);
  assign bus.bus_iow_l  = !(strobe_on && cyc_q == CYC_IOW);
  assign bus.bus_d_out  = wdata_q;
  assign bus.bus_d_oe   = is_write && (state_q != ST_IDLE);
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_isa_master.sv
// Self-checking bench for isa_master: directed bus cycles plus randomized
// commands against a cycle-count reference model.
module tb_isa_master;
  import isa_pkg::*;

  localparam int SETUP_CYC   = 2;
  localparam int STROBE_CYC  = 6;
  localparam int HOLD_CYC    = 1;
  localparam int TIMEOUT_CYC = 16;
`ifdef ISA_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  // Cycle (counted from the accept cycle = 0) of the nominal last strobe-low cycle.
  localparam int LAST_STB = 2 + SETUP_CYC + STROBE_CYC - 1;

  logic       clk = 1'b0;
  logic       busreset = 1'b1;
  isa_state_e state_dbg;
  isa_master_if bus();

  isa_master #(
    .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .busreset(busreset), .bus(bus), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  // ---------------- scoreboard state
  int          checks = 0;
  int          errors = 0;
  int          rsp_count = 0;
  logic [9:0]  exp_q[$];          // {is_read, timeout, rdata}
  logic        prev_rst = 1'b1;
  logic        nxt_wr, nxt_io;
  logic [19:0] nxt_addr;
  logic [7:0]  nxt_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus-wide invariants sampled every cycle.
  always @(negedge clk) begin
    if (!busreset) begin
      check("strobe_overlap", 32'(int'(!bus.bus_ior_l) + int'(!bus.bus_iow_l) +
            int'(!bus.bus_memr_l) + int'(!bus.bus_memw_l) <= 1), 1);
      if (!bus.bus_ior_l || !bus.bus_memr_l) check("read_d_oe", 32'(bus.bus_d_oe), 0);
      if (!prev_rst) check("aen_low", 32'(bus.bus_aen), 0);
      if (bus.rsp_valid) rsp_count++;
    end
    prev_rst = busreset;
  end

  // ---------------- driver + reference model
  // rdy is held low during cycles [lo, hi] relative to the accept cycle.
  task automatic run_txn(input logic wr, input logic io, input logic [19:0] addr,
                         input logic [7:0] wdata, input logic [7:0] dev,
                         input int lo, input int hi, input bit hold_next);
    int          consec, waits, exp_lat, lat, low_sel, c;
    bit          tmo, got;
    logic [19:0] exp_a;
    logic [9:0]  exp;
    logic        sel;
    consec = 0;
    while (LAST_STB + consec >= lo && LAST_STB + consec <= hi) consec++;
    tmo     = TMO_EN && (consec > TIMEOUT_CYC);
    waits   = tmo ? TIMEOUT_CYC : consec;
    exp_lat = 2 + SETUP_CYC + STROBE_CYC + HOLD_CYC + waits;
    exp_a   = io ? {4'h0, addr[15:0]} : addr;
    exp_q.push_back({!wr, tmo, (tmo ? 8'hFF : dev)});

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_io    = io;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    c = 0;
    while (!bus.cmd_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("cmd_ready", 32'(bus.cmd_ready), 1);
    @(posedge clk);
    lat = 0; low_sel = 0; got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("ale_addr", 32'(bus.bus_ale), 1);
        check("bus_a", 32'(bus.bus_a), 32'(exp_a));
        if (hold_next) begin
          bus.cmd_write = nxt_wr;
          bus.cmd_io    = nxt_io;
          bus.cmd_addr  = nxt_addr;
          bus.cmd_wdata = nxt_wdata;
        end else begin
          bus.cmd_valid = 1'b0;
          bus.cmd_addr  = 20'($urandom());
          bus.cmd_wdata = 8'($urandom());
        end
      end
      if (lat == 2) check("ale_setup", 32'(bus.bus_ale), 0);
      if (lat == 2 + SETUP_CYC) begin
        check("d_oe", 32'(bus.bus_d_oe), 32'(wr));
        if (wr) check("d_out", 32'(bus.bus_d_out), 32'(wdata));
        check("bus_a_strobe", 32'(bus.bus_a), 32'(exp_a));
      end
      case ({io, wr})
        2'b00:   sel = bus.bus_memr_l;
        2'b01:   sel = bus.bus_memw_l;
        2'b10:   sel = bus.bus_ior_l;
        default: sel = bus.bus_iow_l;
      endcase
      if (!sel) low_sel++;
      bus.bus_rdy  = !(lat >= lo && lat <= hi);
      bus.bus_d_in = dev;
      if (bus.rsp_valid) got = 1'b1;
    end
    bus.bus_rdy = 1'b1;
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    check("strobe_len", 32'(low_sel), 32'(STROBE_CYC + waits));
    exp = exp_q.pop_front();
    check("rsp_timeout", 32'(bus.rsp_timeout), 32'(exp[8]));
    if (exp[9]) check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp[7:0]));
    if (hold_next) begin
      check("b2b_ready", 32'(bus.cmd_ready), 1);
    end else begin
      @(negedge clk);
      check("rsp_pulse", 32'(bus.rsp_valid), 0);
    end
  endtask

  // ---------------- stimulus
  initial begin
    int base, c, lo, len;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_io    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.bus_rdy   = 1'b1;
    bus.bus_d_in  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_strobes", 32'({bus.bus_ior_l, bus.bus_iow_l, bus.bus_memr_l, bus.bus_memw_l}), 32'hF);
    check("rst_ale", 32'(bus.bus_ale), 0);
    check("rst_aen", 32'(bus.bus_aen), 1);
    check("rst_d_oe", 32'(bus.bus_d_oe), 0);
    check("rst_bus_a", 32'(bus.bus_a), 0);
    check("rst_d_out", 32'(bus.bus_d_out), 0);
    check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata}), 0);
    check("rst_ready", 32'(bus.cmd_ready), 0);
    busreset = 1'b0;
    @(negedge clk);

    // Directed bus cycles
    run_txn(1'b1, 1'b1, 20'h003B4, 8'h0C, 8'h00, 0, -1, 1'b0);
    run_txn(1'b0, 1'b0, 20'hB0000, 8'h00, 8'h41, 0, -1, 1'b0);
    run_txn(1'b0, 1'b1, 20'hF03BA, 8'h00, 8'h5A, 2 + SETUP_CYC + 1, 2 + SETUP_CYC + 5, 1'b0);
    // rdy stuck low long enough to exceed the timeout
    run_txn(1'b0, 1'b0, 20'h0C800, 8'h00, 8'h77, LAST_STB, LAST_STB + 40, 1'b0);

    // Reset during the strobe of a memory write
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_io    = 1'b0;
    bus.cmd_addr  = 20'h12345;
    bus.cmd_wdata = 8'hA5;
    c = 0;
    while (!bus.cmd_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_memw_low", 32'(bus.bus_memw_l), 0);
    base = rsp_count;
    busreset = 1'b1;
    @(negedge clk);
    check("abort_memw", 32'(bus.bus_memw_l), 1);
    check("abort_d_oe", 32'(bus.bus_d_oe), 0);
    check("abort_ready", 32'(bus.cmd_ready), 0);
    check("abort_rsp", 32'(bus.rsp_valid), 0);
    busreset = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.cmd_ready), 1);
    repeat (15) @(negedge clk);
    check("abort_no_rsp", 32'(rsp_count - base), 0);

    // Back-to-back: second command held valid and accepted on first rsp_valid
    base      = rsp_count;
    nxt_wr    = 1'b0;
    nxt_io    = 1'b1;
    nxt_addr  = 20'h70379;
    nxt_wdata = 8'h00;
    run_txn(1'b1, 1'b0, 20'hA1234, 8'h3C, 8'h00, 0, -1, 1'b1);
    run_txn(nxt_wr, nxt_io, nxt_addr, nxt_wdata, 8'hC3, 0, -1, 1'b0);
    repeat (3) @(negedge clk);
    check("b2b_pulses", 32'(rsp_count - base), 2);

    // Randomized commands and wait-state windows
    for (int i = 0; i < 12; i++) begin
      lo  = $urandom_range(LAST_STB + 1, LAST_STB - 3);
      len = $urandom_range(6, 0);
      run_txn(1'($urandom()), 1'($urandom()), 20'($urandom()), 8'($urandom()),
              8'($urandom()), lo, lo + len - 1, 1'b0);
    end

    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/isa_master.md
ISA_MASTER -- requirements
Module: isa_master

Interface
REQ-001 Parameter SETUP_CYC, default 2, cycles from address latch to strobe assertion (min 1).
REQ-002 Parameter STROBE_CYC, default 6, minimum strobe-low cycles (min 2).
REQ-003 Parameter HOLD_CYC, default 1, cycles address/data held after strobe release (min 1).
REQ-004 Parameter TIMEOUT_CYC, default 1024, maximum wait-state cycles before abort.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 busreset  in  1  synchronous, active-high reset.
REQ-007 cmd_valid  in  1  host command request; cmd_ready  out  1  command accepted when both high.
REQ-008 cmd_write  in  1  1=write, 0=read; cmd_io  in  1  1=I/O cycle, 0=memory cycle.
REQ-009 cmd_addr  in  20  target address; cmd_wdata  in  8  write data.
REQ-010 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  8  read data; rsp_timeout  out  1  cycle aborted.
REQ-011 bus_a  out  20; bus_ale  out  1; bus_aen  out  1; bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l  out  1 each, active-low strobes.
REQ-012 bus_d_out  out  8; bus_d_oe  out  1  data driver enable; bus_d_in  in  8  sampled bus data.
REQ-013 bus_rdy  in  1  IOCHRDY, low = insert wait states.

Function
REQ-014 States: IDLE, ADDR, SETUP, STROBE, WAIT, HOLD; cmd_ready SHALL be high only in IDLE.
REQ-015 Accept (cmd_valid & cmd_ready) latches all cmd_* fields and moves to ADDR next cycle; cmd_* changes afterwards are ignored until next IDLE.
REQ-016 ADDR: exactly 1 cycle, bus_a driven, bus_ale=1; I/O cycles force bus_a[19:16]=0.
REQ-017 SETUP: SETUP_CYC cycles, bus_ale=0, bus_a held; writes assert bus_d_oe with bus_d_out=latched data from ADDR through HOLD.
REQ-018 STROBE: exactly one strobe low, selected by (cmd_io, cmd_write), for STROBE_CYC cycles.
REQ-019 Last STROBE cycle: bus_rdy=1 -> HOLD; bus_rdy=0 -> WAIT with strobe kept low.
REQ-020 WAIT: remain while bus_rdy=0; first cycle bus_rdy=1 -> HOLD.
REQ-021 Reads capture bus_d_in into rsp_rdata on the final strobe-low cycle (transition into HOLD).
REQ-022 HOLD: HOLD_CYC cycles, all strobes high, bus_a and write data held; then IDLE with rsp_valid=1 for exactly that first IDLE cycle.
REQ-023 Zero-wait latency: rsp_valid asserted 2+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles after accept cycle (11 with defaults); each WAIT cycle adds 1.
REQ-024 A new command accepted in the rsp_valid cycle SHALL be legal (back-to-back).
REQ-025 bus_aen=0 at all times outside reset; strobes never overlap; bus_d_oe never high during reads.
REQ-026 rsp_timeout=0 on every normal completion.

Reset
REQ-027 busreset sampled high: next cycle state=IDLE, all strobes=1, bus_ale=0, bus_aen=1, bus_d_oe=0, bus_a=0, bus_d_out=0, rsp_valid=0, rsp_timeout=0, rsp_rdata=0, cmd_ready=0 while busreset high.
REQ-028 Reset mid-cycle SHALL abort without rsp_valid; cmd_ready returns 1 first cycle after busreset falls.

Configuration
REQ-029 Macro ISA_MASTER_TIMEOUT_EN defined: WAIT counter aborts after TIMEOUT_CYC cycles -> HOLD, rsp_rdata=8'hFF, rsp_timeout=1 with rsp_valid.
REQ-030 Macro undefined: WAIT unbounded, no counter logic, rsp_timeout tied 0.

Structure
REQ-031 Package isa_pkg holds state enum and cycle-type encoding (MEMR, MEMW, IOR, IOW) plus default timing constants.
REQ-032 Sub-module isa_cycle_timer: loadable down-counter with zero flag, shared by SETUP/STROBE/HOLD/timeout counting.

Verification
REQ-033 I/O write addr 0x003B4 data 0x0C, rdy=1 -> bus_a=0x003B4, bus_iow_l low 6 cycles, bus_d_out=0x0C, rsp_valid 11 cycles after accept.
REQ-034 Mem read 0xB0000, model drives 0x41, rdy=1 -> bus_memr_l low 6 cycles, rsp_rdata=0x41, rsp_timeout=0.
REQ-035 I/O read 0xF03BA with rdy low 5 cycles from strobe start -> bus_a=0x003BA, strobe low 7 cycles, rsp_valid at 12 cycles.
REQ-036 TIMEOUT_EN, TIMEOUT_CYC=16, rdy stuck low -> strobe released after 16 WAIT cycles, rsp_rdata=0xFF, rsp_timeout=1.
REQ-037 busreset high during STROBE of a memory write -> bus_memw_l=1, bus_d_oe=0 next cycle, no rsp_valid.
REQ-038 Two commands held valid continuously -> second accepted on first's rsp_valid cycle, exactly two rsp_valid pulses, strobes never overlap.
